// File: rtl/goose_pkg.sv
// Shared types and constants for the goose-run game controller.
package goose_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  localparam int unsigned SCORE_DIGITS = 4;
  localparam int unsigned SCORE_W      = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  // Add one to a packed BCD value, rippling the decimal carry digit by digit.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Four-digit BCD up-counter with synchronous clear, saturating at 9999.
module bcd_counter
  import goose_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  logic [SCORE_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && (count != SCORE_MAX)) begin
      count_nxt = bcd_inc(count);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/goose_game_ctrl.sv
// Goose-run game flow: button debounce, IDLE/RUN/HIT/OVER sequencing,
// BCD running score and high-score register.
module goose_game_ctrl
  import goose_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 40_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_jump,
  input  logic               collide,
  input  logic               frame_end,
  output logic [1:0]         state,
  output logic               playing,
  output logic               hit,
  output logic               restart_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] score_hi,
  output logic               new_hi,
  output logic [15:0]        led
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  logic              sync_1;
  logic              sync_2;
  logic              db;
  logic              db_q;
  logic [DB_W-1:0]   db_cnt;
  logic              press;

  state_t            st;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_wrap;
  logic              start;
  logic              score_inc;

  // The stable count only advances while the synchronized level disagrees
  // with db; any return to the old level restarts the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      db     <= 1'b0;
      db_q   <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync_1 <= btn_jump;
      sync_2 <= sync_1;
      db_q   <= db;
      if (sync_2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= sync_2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press     = db & ~db_q;
  assign start     = press && ((st == ST_IDLE) || (st == ST_OVER));
  assign tick_wrap = (st == ST_RUN) && (tick_cnt == TICK_LAST);
  assign score_inc = tick_wrap && !collide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (start) begin
      tick_cnt <= '0;
    end else if (st == ST_RUN) begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= ST_IDLE;
      restart_pulse <= 1'b0;
      new_hi        <= 1'b0;
      score_hi      <= '0;
    end else begin
      restart_pulse <= 1'b0;
      case (st)
        ST_IDLE, ST_OVER: begin
          if (press) begin
            st            <= ST_RUN;
            restart_pulse <= 1'b1;
            new_hi        <= 1'b0;
          end
        end
        ST_RUN: begin
          if (collide) begin
            st <= ST_HIT;
          end
        end
        ST_HIT: begin
          if (frame_end) begin
            st <= ST_OVER;
            // BCD digit order matches binary order, so a plain compare works.
            if (score > score_hi) begin
              score_hi <= score;
              new_hi   <= 1'b1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  bcd_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (score_inc),
    .count (score)
  );

  assign state   = st;
  assign playing = (st == ST_RUN);
  assign hit     = (st == ST_HIT) || (st == ST_OVER);
  assign led     = score;

endmodule

// File: tb/tb_goose_game_ctrl.sv
// Randomized self-checking bench for goose_game_ctrl with a timing-level reference model.
module tb_goose_game_ctrl;

  localparam int TDIV   = 10;
  localparam int TDIV_B = 2;

  logic clk = 1'b0;
  logic reset;
  logic btn, collide, frame_end;
  logic [1:0]  state;
  logic        playing, hit, restart_pulse, new_hi;
  logic [15:0] score, score_hi, led;

  logic btn_b, collide_b, frame_end_b;
  logic [1:0]  state_b;
  logic        playing_b, hit_b, restart_pulse_b, new_hi_b;
  logic [15:0] score_b, score_hi_b, led_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: score follows directly from cycles spent in RUN.
  bit m_run   = 1'b0;
  bit m_run_b = 1'b0;
  int run_edges   = 0;
  int run_edges_b = 0;
  int exp_frozen  = 0;
  int hi_model    = 0;
  bit new_model   = 1'b0;

  always #5 clk = ~clk;

  goose_game_ctrl #(.TICK_DIV(TDIV), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_jump(btn), .collide(collide), .frame_end(frame_end),
    .state(state), .playing(playing), .hit(hit), .restart_pulse(restart_pulse),
    .score(score), .score_hi(score_hi), .new_hi(new_hi), .led(led)
  );

  goose_game_ctrl #(.TICK_DIV(TDIV_B), .DEBOUNCE_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .btn_jump(btn_b), .collide(collide_b), .frame_end(frame_end_b),
    .state(state_b), .playing(playing_b), .hit(hit_b), .restart_pulse(restart_pulse_b),
    .score(score_b), .score_hi(score_hi_b), .new_hi(new_hi_b), .led(led_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (m_run)   run_edges++;
      if (m_run_b) run_edges_b++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, {14'd0, state}, 16'h0000);
    check({tag, "_playing"}, {15'd0, playing}, 16'h0000);
    check({tag, "_hit"}, {15'd0, hit}, 16'h0000);
    check({tag, "_restart"}, {15'd0, restart_pulse}, 16'h0000);
    check({tag, "_score"}, score, 16'h0000);
    check({tag, "_score_hi"}, score_hi, 16'h0000);
    check({tag, "_new_hi"}, {15'd0, new_hi}, 16'h0000);
    check({tag, "_led"}, led, 16'h0000);
  endtask

  // Button held from edge 0: 2 sync edges + 4 stable edges -> db, RUN on edge 7.
  task automatic start_a();
    btn = 1'b0;
    tick(8);
    btn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check("restart_pulse", {15'd0, restart_pulse}, {15'd0, (i == 7)});
      if (i == 7) begin
        check("entry_state", {14'd0, state}, 16'h0001);
        check("entry_score", score, 16'h0000);
        check("entry_new_hi", {15'd0, new_hi}, 16'h0000);
        m_run     = 1'b1;
        run_edges = 0;
      end
    end
    btn = 1'b0;
  endtask

  task automatic run_to(input int target);
    int n;
    while (run_edges < target) begin
      n = $urandom_range(1, ((target - run_edges) < 23) ? (target - run_edges) : 23);
      btn       = 1'($urandom_range(0, 1));
      frame_end = ($urandom_range(0, 7) == 0);
      tick(n);
      frame_end = 1'b0;
      check("run_state", {14'd0, state}, 16'h0001);
      check("run_score", score, to_bcd(run_edges / TDIV));
      check("run_led", led, to_bcd(run_edges / TDIV));
    end
  endtask

  // Collide wins over a simultaneous tick, so the score is the pre-edge value.
  task automatic do_collide();
    int w;
    exp_frozen = run_edges / TDIV;
    if (exp_frozen > 9999) exp_frozen = 9999;
    btn       = 1'b0;
    frame_end = 1'b0;
    collide   = 1'b1;
    m_run     = 1'b0;
    tick(1);
    collide = 1'b0;
    check("hit_state", {14'd0, state}, 16'h0002);
    check("hit_flag", {15'd0, hit}, 16'h0001);
    check("hit_playing", {15'd0, playing}, 16'h0000);
    check("hit_score", score, to_bcd(exp_frozen));
    w = $urandom_range(8, 15);
    for (int i = 0; i < w; i++) begin
      collide = 1'($urandom_range(0, 1));
      tick(1);
      check("hit_hold_state", {14'd0, state}, 16'h0002);
      check("hit_hold_score", score, to_bcd(exp_frozen));
    end
    collide = 1'b0;
  endtask

  task automatic end_game();
    frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
    if (exp_frozen > hi_model) begin
      hi_model  = exp_frozen;
      new_model = 1'b1;
    end else begin
      new_model = 1'b0;
    end
    check("over_state", {14'd0, state}, 16'h0003);
    check("over_hit", {15'd0, hit}, 16'h0001);
    check("over_score", score, to_bcd(exp_frozen));
    check("over_score_hi", score_hi, to_bcd(hi_model));
    check("over_new_hi", {15'd0, new_hi}, {15'd0, new_model});
  endtask

  task automatic run_b_to(input int target);
    int n;
    while (run_edges_b < target) begin
      n = $urandom_range(1, ((target - run_edges_b) < 997) ? (target - run_edges_b) : 997);
      tick(n);
      check("b_state", {14'd0, state_b}, 16'h0001);
      check("b_score", score_b, to_bcd(run_edges_b / TDIV_B));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; btn = 1'b0; collide = 1'b0; frame_end = 1'b0;
    btn_b = 1'b0; collide_b = 1'b0; frame_end_b = 1'b0;
    tick(3);
    check_all_zero("in_reset");
    reset = 1'b1;
    tick(1);
    check_all_zero("post_reset");

    collide = 1'b1;
    tick(5);
    collide = 1'b0;
    check("idle_collide_state", {14'd0, state}, 16'h0000);

    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      tick(2);
      check("bounce_state", {14'd0, state}, 16'h0000);
      check("bounce_restart", {15'd0, restart_pulse}, 16'h0000);
    end
    btn = 1'b0;

    // Game 1: long scoring run, press ignored in HIT, held button never restarts.
    start_a();
    run_to(1000);
    check("score_100", score, 16'h0100);
    run_to(1000 + $urandom_range(0, 200));
    do_collide();
    btn = 1'b1;
    tick(10);
    check("hit_press_ignored", {14'd0, state}, 16'h0002);
    end_game();
    tick(10);
    check("held_btn_no_restart", {14'd0, state}, 16'h0003);
    check("held_btn_no_pulse", {15'd0, restart_pulse}, 16'h0000);
    btn = 1'b0;

    // Game 2: asynchronous reset in the middle of a run.
    start_a();
    run_to(70 + $urandom_range(0, 9));
    check("score_7", score, 16'h0007);
    btn = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    m_run = 1'b0;
    hi_model = 0;
    tick(2);
    reset = 1'b1;
    tick(2);
    check("after_reset_state", {14'd0, state}, 16'h0000);

    // Game 3: collide coincides with the wrap that would give 0x0042.
    start_a();
    run_to(419);
    check("pre_wrap_score", score, 16'h0041);
    do_collide();
    check("collide_wins", score, 16'h0041);
    end_game();
    check("hi_41", score_hi, 16'h0041);

    // Game 4: lower score leaves the high score alone.
    start_a();
    run_to(120 + $urandom_range(0, 9));
    do_collide();
    check("score_12", score, 16'h0012);
    end_game();
    check("hi_kept", score_hi, 16'h0041);
    check("no_new_hi", {15'd0, new_hi}, 16'h0000);

    for (int g = 0; g < 4; g++) begin
      start_a();
      run_to($urandom_range(5, 700));
      do_collide();
      end_game();
    end

    // Second instance with a fast tick to reach saturation.
    btn_b = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      check("b_restart_pulse", {15'd0, restart_pulse_b}, {15'd0, (i == 7)});
      if (i == 7) begin
        m_run_b     = 1'b1;
        run_edges_b = 0;
      end
    end
    btn_b = 1'b0;
    run_b_to(9998 * TDIV_B);
    check("b_score_9998", score_b, 16'h9998);
    run_b_to(9998 * TDIV_B + 3 * TDIV_B);
    check("b_score_sat", score_b, 16'h9999);
    run_b_to(9998 * TDIV_B + 40 * TDIV_B);
    check("b_score_sat_hold", score_b, 16'h9999);
    check("b_led_sat", led_b, 16'h9999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
